// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD arithmetic blocks.
// The digit validity helper is used by the subtractor's start-time check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CMPL = 2'd2,
    DONE = 2'd3
  } bcd_sub_state_t;

  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  function automatic logic digit_ok(input logic [BCD_W-1:0] x);
    return (x <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_serial_sub_if.sv
// Request/result bundle of the BCD serial subtractor.
// The master drives operands and the start strobe; the slave returns the results.
interface bcd_serial_sub_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  ovf;
  logic                  err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, neg, ovf, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, neg, ovf, err
  );
endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtract with borrow: d = x - y - bi, folded into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             bi,
  output logic [BCD_W-1:0] d,
  output logic             bo
);

  logic signed [4:0] t_s;
  logic signed [4:0] adj_s;

  // t spans -10..9, so bit 4 is the sign and doubles as the borrow-out
  always_comb begin
    t_s   = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bi});
    adj_s = t_s + 5'sd10;
    if (t_s[4]) begin
      d  = adj_s[3:0];
      bo = 1'b1;
    end else begin
      d  = t_s[3:0];
      bo = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor, LSB first; negative results are converted to
// sign + magnitude by a second serial ten's-complement pass over the result.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_sub_if.slave    bus
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_sub_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             in_err_s;
  logic [BCD_W-1:0] x_s, y_s, d_s;
  logic             bo_s;

  // Flag any operand digit outside 0..9 at request time
  always_comb begin
    in_err_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      in_err_s = in_err_s | ~digit_ok(bus.a[i*BCD_W +: BCD_W])
                          | ~digit_ok(bus.b[i*BCD_W +: BCD_W]);
    end
  end

  // The complement pass reuses the subtractor as 0 - d_i
  always_comb begin
    if (state_q == CMPL) begin
      x_s = '0;
      y_s = diff_q[int'(idx_q)*BCD_W +: BCD_W];
    end else begin
      x_s = a_q[int'(idx_q)*BCD_W +: BCD_W];
      y_s = b_q[int'(idx_q)*BCD_W +: BCD_W];
    end
  end

  bcd_digit_sub u_digit (
    .x  (x_s),
    .y  (y_s),
    .bi (borrow_q),
    .d  (d_s),
    .bo (bo_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          diff_d   = '0;
          neg_d    = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          if (in_err_s) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SUB;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SUB: begin
        diff_d[int'(idx_q)*BCD_W +: BCD_W] = d_s;
        borrow_d = bo_s;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (bo_s) begin
            neg_d    = 1'b1;
            borrow_d = 1'b0;
            state_d  = CMPL;
          end else begin
            state_d  = DONE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      CMPL: begin
        diff_d[int'(idx_q)*BCD_W +: BCD_W] = d_s;
        borrow_d = bo_s;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          // No final borrow means the magnitude was exactly 10^DIGITS
          if (!bo_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = 1'b0;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed self-checking bench for bcd_serial_sub (DIGITS=4).
module tb_bcd_serial_sub;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  bcd_serial_sub_if #(.DIGITS(4)) bus ();

  bcd_serial_sub #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request just after an edge; returns after the accepting edge E0 (+1).
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic binv);
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = binv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hEEEE;
    bus.bin   = 1'b1;
  endtask

  // Counts edges after E0 until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    bus.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.diff, bus.neg, bus.ovf, bus.err} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.busy, bus.done, bus.diff, bus.neg, bus.ovf, bus.err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_simple();
    int lat;
    issue(16'h9999, 16'h0001, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL simple_busy: got %b want 1", bus.busy); end
    // a start while busy must be ignored
    bus.a = 16'h0000; bus.b = 16'h0005; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    lat = lat + 1;
    n_vec++;
    if (lat !== 5) begin n_err++; $display("FAIL simple_latency: got %0d want 5", lat); end
    n_vec++;
    if ({bus.diff, bus.neg, bus.ovf, bus.err, bus.busy} !== {16'h9998, 4'b0000}) begin
      n_err++;
      $display("FAIL simple_result: diff=%h neg=%b ovf=%b err=%b busy=%b want 9998/0/0/0/0",
               bus.diff, bus.neg, bus.ovf, bus.err, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.done, bus.diff} !== {1'b0, 16'h9998}) begin
      n_err++;
      $display("FAIL simple_hold: done=%b diff=%h want 0/9998", bus.done, bus.diff);
    end
  endtask

  task automatic test_ripple();
    int lat;
    issue(16'h1000, 16'h0001, 1'b0);
    wait_done(lat);
    n_vec++;
    if ({bus.diff, bus.neg, lat} !== {16'h0999, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL ripple: diff=%h neg=%b lat=%0d want 0999/0/5", bus.diff, bus.neg, lat);
    end
    @(posedge clk); #1;
    issue(16'h0500, 16'h0200, 1'b1);
    wait_done(lat);
    n_vec++;
    if ({bus.diff, bus.neg} !== {16'h0299, 1'b0}) begin
      n_err++;
      $display("FAIL borrow_in: diff=%h neg=%b want 0299/0", bus.diff, bus.neg);
    end
  endtask

  task automatic test_negative();
    int lat;
    issue(16'h0123, 16'h0456, 1'b0);
    wait_done(lat);
    n_vec++;
    if (lat !== 9) begin n_err++; $display("FAIL neg_latency: got %0d want 9", lat); end
    n_vec++;
    if ({bus.diff, bus.neg, bus.ovf, bus.err} !== {16'h0333, 3'b100}) begin
      n_err++;
      $display("FAIL neg_result: diff=%h neg=%b ovf=%b err=%b want 0333/1/0/0",
               bus.diff, bus.neg, bus.ovf, bus.err);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL neg_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_ovf();
    int lat;
    issue(16'h0000, 16'h9999, 1'b1);
    wait_done(lat);
    n_vec++;
    if ({bus.diff, bus.neg, bus.ovf, lat} !== {16'h0000, 2'b11, 32'd9}) begin
      n_err++;
      $display("FAIL ovf: diff=%h neg=%b ovf=%b lat=%0d want 0000/1/1/9",
               bus.diff, bus.neg, bus.ovf, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'h00A1, 16'h0000, 1'b0);
    wait_done(lat);
    n_vec++;
    if ({bus.err, bus.diff, lat} !== {1'b1, 16'h0000, 32'd1}) begin
      n_err++;
      $display("FAIL err: err=%b diff=%h lat=%0d want 1/0000/1", bus.err, bus.diff, lat);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL err_busy_in_done: got %b want 0", bus.busy); end
    issue(16'h4321, 16'h4321, 1'b0);
    n_vec++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b err=%b want 1/0", bus.busy, bus.err);
    end
    wait_done(lat);
    n_vec++;
    if ({bus.diff, bus.neg, bus.err, lat} !== {16'h0000, 2'b00, 32'd5}) begin
      n_err++;
      $display("FAIL b2b_result: diff=%h neg=%b err=%b lat=%0d want 0000/0/0/5",
               bus.diff, bus.neg, bus.err, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    issue(16'h0123, 16'h0456, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.diff, bus.neg, bus.ovf, bus.err} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {bus.busy, bus.done, bus.diff, bus.neg, bus.ovf, bus.err});
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
      if (bus.done === 1'b1) seen++;
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", seen); end
    issue(16'h0005, 16'h0003, 1'b0);
    wait_done(lat);
    n_vec++;
    if ({bus.diff, bus.neg, lat} !== {16'h0002, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL reset_mid_recover: diff=%h neg=%b lat=%0d want 0002/0/5", bus.diff, bus.neg, lat);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_simple();
    test_ripple();
    test_negative();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_sub.md
# bcd_serial_sub

Digit-serial, multi-digit BCD subtractor: the subtract-side counterpart of the team's BCD adder. It accepts two packed BCD operands on a start strobe and processes one digit per clock, LSB first. A negative result is returned as sign plus magnitude, using a second serial ten's-complement pass. It sits beside the BCD adder in the arithmetic datapath and uses the same one-request, one-`done` handshake as the other multi-cycle blocks.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand (≥1).
- `clk`  in  1: rising-edge clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request strobe, sampled only when `busy`=0.
- `a`  in  4*DIGITS: minuend, packed BCD, digit 0 in [3:0].
- `b`  in  4*DIGITS: subtrahend, packed BCD.
- `bin`  in  1: borrow-in, subtracted at digit 0.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse when results are valid.
- `diff`  out  4*DIGITS: result magnitude in BCD.
- `neg`  out  1: result is negative.
- `ovf`  out  1: magnitude equals 10^DIGITS; `diff`=0 in this case.
- `err`  out  1: an input digit was greater than 9.

## Operation
- FSM states: IDLE, SUB, CMPL, DONE.
- IDLE with `start`=1:
  - Latch `a`, `b`, `bin`, clear the digit index, clear `neg`/`ovf`/`err`, set `busy`.
  - If any digit of `a` or `b` is greater than 9: set `err`, set `diff`=0, go to DONE.
  - Otherwise go to SUB.
- SUB, digit i (one per cycle):
  - t = a_i − b_i − borrow (borrow starts at `bin`).
  - If t<0: d_i = t+10 and borrow=1. Otherwise d_i = t and borrow=0.
  - Write d_i into the `diff` register.
  - After digit DIGITS−1: if final borrow=0, go to DONE. If final borrow=1, set `neg`, reset the index and borrow to 0, go to CMPL.
- CMPL: d_i ← 0 − d_i − borrow, using the same digit rule (ten's complement = 0 − X).
  - After the last digit: a final borrow of 0 means X was 0, i.e. the true magnitude is 10^DIGITS. Set `ovf`=1 and leave `diff`=0.
  - Then go to DONE.
- DONE: assert `done` for exactly one cycle, clear `busy`, go to IDLE.
- `diff`, `neg`, `ovf`, `err` hold their values until the next accepted `start`.
- `start` while `busy`=1 is ignored; no queuing.
- `a`/`b`/`bin` may change freely after the accepting edge.
- Arithmetic: digits 0..9 only. Intermediate t ranges from −10 to 9 and is held in 5-bit signed.

## Timing
- Reset (asynchronous assert, synchronous deassert as seen by the FSM): state=IDLE, `busy`=0, `done`=0, `diff`=0, `neg`=0, `ovf`=0, `err`=0.
- Reset mid-operation aborts immediately with no `done`.
- Edge E0 is the edge that accepts `start`. `busy`=1 from E0 onward.
- `done`=1 in the cycle following:
  - E(DIGITS+1) for a non-negative result;
  - E(2*DIGITS+1) for a negative result;
  - E1 for `err`.
- `busy` falls on the same edge `done` rises. Results are valid on that edge and stay stable afterwards.
- `start`=1 in the `done` cycle is accepted (`busy`=0 then), giving back-to-back throughput.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `bcd_pkg`:
  - state enum `bcd_sub_state_t` (IDLE/SUB/CMPL/DONE);
  - `BCD_W`=4;
  - `BCD_MAX`=9;
  - `BCD_BASE`=10.
- Sub-module `bcd_digit_sub`: combinational single-digit subtract with borrow (inputs x, y, bi; outputs d, bo).
  - One instance serves both SUB (x=a_i, y=b_i) and CMPL (x=0, y=d_i) through an input mux.
- Top level holds the FSM, digit index counter, borrow flop and result shift/index register.

## Test plan
- DIGITS=4, a=0x9999, b=0x0001, bin=0 → `diff`=0x9998, `neg`=0, `done` in the cycle after E5.
- a=0x1000, b=0x0001 → `diff`=0x0999, `neg`=0 (borrow ripples across three digits).
- a=0x0123, b=0x0456 → `diff`=0x0333, `neg`=1, `done` in the cycle after E9.
- a=0x0000, b=0x9999, bin=1 → `diff`=0x0000, `neg`=1, `ovf`=1.
- a=0x00A1, b=0x0000 → `err`=1, `diff`=0, `done` in the cycle after E1.
  - Then `start` in the `done` cycle with a=b=0x4321 → accepted; `diff`=0, `neg`=0, `err` cleared.
- `rst_n` pulsed low during CMPL → all outputs 0 immediately, no `done`.
  - Then `start` with a=0x0005, b=0x0003 → `diff`=0x0002 on normal latency.
